// File: rtl/rgmii_rx_framer.sv
// -----------------------------------------------------------------------------
// rgmii_rx_framer
//
// Turns the per-pin IDDR captures of an RGMII receive interface into a framed
// byte stream for the MAC RX path. Preamble and SFD are stripped. Frames are
// delimited by RX_DV. Short, oversized or RX_ER-tainted frames are flagged on
// the last beat. Good and bad frames are counted in saturating counters.
// There is no backpressure: at most one byte per clock, at line rate.
//
// Ports
//   clk            RGMII RX clock (same clock as the IDDRs)
//   rst            asynchronous, active-high reset
//   en             receive enable, only honoured while idle
//   rxd_q0         IDDR q[0] of RXD[3:0] (rising-edge capture, low nibble)
//   rxd_q1         IDDR q[1] of RXD[3:0] (falling-edge capture, high nibble)
//   rxctl_q        IDDR q of RX_CTL: [0]=RX_DV, [1]=RX_DV^RX_ER
//   m_data         received byte
//   m_valid        m_data valid this cycle
//   m_last         final byte of frame (qualified by m_valid)
//   m_err          frame bad (qualified by m_last)
//   frame_ok_cnt   frames ended with m_err=0, saturating
//   frame_err_cnt  frames ended with m_err=1 (incl. empty frames), saturating
//
// Latency: a payload byte appears on m_data 3 clocks after its input cycle.
// One byte is always parked in a hold register so that the end-of-frame
// (RX_DV falling) can be attached to the last byte as m_last.
// -----------------------------------------------------------------------------
module rgmii_rx_framer #(
  parameter int MIN_PREAMBLE = 1,    // must be >= 1
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       rxd_q0,
  input  logic [3:0]       rxd_q1,
  input  logic [1:0]       rxctl_q,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_err,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  localparam int BCNT_W = $clog2(MAX_FRAME + 1);
  localparam int PCNT_W = (MIN_PREAMBLE > 1) ? $clog2(MIN_PREAMBLE + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [7:0]        PRE_BYTE = 8'h55;
  localparam logic [7:0]        SFD_BYTE = 8'hD5;
  localparam logic [BCNT_W-1:0] MAX_CNT  = BCNT_W'(MAX_FRAME);
  localparam logic [BCNT_W-1:0] MIN_CNT  = BCNT_W'(MIN_FRAME);
  localparam logic [PCNT_W-1:0] PRE_SAT  = PCNT_W'(MIN_PREAMBLE);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Input stage s1: everything the FSM looks at is registered once here.
  logic [7:0]        r_s1_byte;
  logic              r_s1_dv;
  logic              r_s1_er;
  logic              r_s1_en;

  logic [1:0]        r_state;
  logic [PCNT_W-1:0] r_pre_cnt;
  logic [BCNT_W-1:0] r_byte_cnt;
  logic [7:0]        r_hold;
  logic              r_hold_full;
  logic              r_sticky;

  logic [7:0]        r_m_data;
  logic              r_m_valid;
  logic              r_m_last;
  logic              r_m_err;
  logic [CNT_W-1:0]  r_ok_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [1:0]        w_state_nxt;
  logic              w_load;       // capture s1 byte into hold register
  logic              w_emit;       // hold register goes out next cycle
  logic              w_emit_last;
  logic              w_emit_err;
  logic              w_empty_end;  // SFD followed directly by RX_DV low

  // NOTE: every signal gets a default before the case/if tree; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_emit      = 1'b0;
    w_emit_last = 1'b0;
    w_emit_err  = 1'b0;
    w_empty_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // RX_DV low with RX_ER high is in-band status / carrier extension.
        if (r_s1_en && r_s1_dv)
          w_state_nxt = (r_s1_byte == PRE_BYTE) ? ST_PRE : ST_DROP;
      end
      ST_PRE: begin
        if (!r_s1_dv)
          w_state_nxt = ST_IDLE;
        else if (r_s1_byte == PRE_BYTE)
          w_state_nxt = ST_PRE;
        else if (r_s1_byte == SFD_BYTE && r_pre_cnt >= PRE_SAT)
          w_state_nxt = ST_DATA;
        else
          w_state_nxt = ST_DROP;
      end
      ST_DATA: begin
        if (!r_s1_dv) begin
          w_state_nxt = ST_IDLE;
          if (r_hold_full) begin
            w_emit      = 1'b1;
            w_emit_last = 1'b1;
            w_emit_err  = r_sticky | (r_byte_cnt < MIN_CNT);
          end else begin
            w_empty_end = 1'b1;
          end
        end else if (r_byte_cnt == MAX_CNT) begin
          // One byte past the limit: close the frame on the held byte and
          // discard the remainder.
          w_state_nxt = ST_DROP;
          w_emit      = 1'b1;
          w_emit_last = 1'b1;
          w_emit_err  = 1'b1;
        end else begin
          w_load = 1'b1;
          w_emit = r_hold_full;
        end
      end
      ST_DROP: begin
        if (!r_s1_dv)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side below reads the pre-edge value regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_byte   <= '0;
      r_s1_dv     <= 1'b0;
      r_s1_er     <= 1'b0;
      r_s1_en     <= 1'b0;
      r_state     <= ST_IDLE;
      r_pre_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sticky    <= 1'b0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_err     <= 1'b0;
      r_ok_cnt    <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_s1_byte <= {rxd_q1, rxd_q0};
      r_s1_dv   <= rxctl_q[0];
      r_s1_er   <= rxctl_q[0] ^ rxctl_q[1];
      r_s1_en   <= en;

      r_state <= w_state_nxt;

      // The first 0x55 is counted by the IDLE->PRE transition itself.
      if (r_state == ST_IDLE)
        r_pre_cnt <= PCNT_W'(1);
      else if (r_state == ST_PRE && r_s1_dv && r_s1_byte == PRE_BYTE &&
               r_pre_cnt != PRE_SAT)
        r_pre_cnt <= r_pre_cnt + 1'b1;

      // Frame context is cleared while still in PRE, so DATA always starts
      // with an empty hold register and zero count.
      if (r_state == ST_PRE) begin
        r_byte_cnt  <= '0;
        r_hold_full <= 1'b0;
        r_sticky    <= 1'b0;
      end else if (w_load) begin
        r_hold      <= r_s1_byte;
        r_hold_full <= 1'b1;
        r_byte_cnt  <= r_byte_cnt + 1'b1;
        r_sticky    <= r_sticky | r_s1_er;
      end else if (w_emit_last || w_empty_end) begin
        r_hold_full <= 1'b0;
      end

      r_m_valid <= w_emit;
      r_m_last  <= w_emit_last;
      r_m_err   <= w_emit_err;
      if (w_emit)
        r_m_data <= r_hold;

      if (w_emit_last && !w_emit_err && r_ok_cnt != CNT_MAX)
        r_ok_cnt <= r_ok_cnt + 1'b1;
      if (((w_emit_last && w_emit_err) || w_empty_end) && r_err_cnt != CNT_MAX)
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign m_data        = r_m_data;
  assign m_valid       = r_m_valid;
  assign m_last        = r_m_last;
  assign m_err         = r_m_err;
  assign frame_ok_cnt  = r_ok_cnt;
  assign frame_err_cnt = r_err_cnt;

endmodule
